// File: rtl/decoder_host.sv
// Host-side wrapper for an LDPC-style decoder: streams an LLR vector to the decoder
// in beats, then collects the decoded codeword back and flags receive timeouts.
module decoder_host #(
  parameter int WIDTH_IN  = 8,
  parameter int N_LLRS    = 4,
  parameter int WIDTH_OUT = 8,
  parameter int N_V       = 31,
  parameter int TIMEOUT   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH_IN*N_V-1:0]      llr_in,
  input  logic                         hold,
  output logic                         ready,
  output logic [N_V-1:0]               cw,
  output logic                         cw_valid,
  output logic                         error,
  output logic [N_LLRS*WIDTH_IN-1:0]   dec_databus,
  output logic                         dec_first_data,
  output logic                         dec_data_valid,
  input  logic                         dec_busy,
  input  logic                         dec_out_ready,
  output logic                         dec_first_data_out,
  input  logic [WIDTH_OUT-1:0]         dec_databus_out,
  input  logic                         dec_data_valid_out,
  output logic [2:0]                   dbg_state_o
);

  localparam int LLR_CHUNK       = N_LLRS * WIDTH_IN;
  localparam int VEC_W           = WIDTH_IN * N_V;
  localparam int L_SEG           = (N_V - 1) / N_LLRS;
  localparam int FIRST_CHUNK     = ((N_V - 1) % N_LLRS + 1) * WIDTH_IN;
  localparam int L_SEG_OUT       = (N_V - 1) / WIDTH_OUT;
  localparam int FIRST_CHUNK_OUT = (N_V - 1) % WIDTH_OUT + 1;
  // Shift register carries one spare chunk of zeros so every slice stays in range.
  localparam int SR_W            = VEC_W + LLR_CHUNK;

  // Handshake: a beat transfers in any cycle where dec_data_valid=1; there is no
  // backpressure on a beat once driven -- the host gates beats with dec_busy/hold.
  typedef enum logic [2:0] {
    S_IDLE, S_SEND_F, S_SEND, S_WAIT_RDY, S_RECV, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [N_V-1:0]    asm_q, asm_d;
  logic [N_V-1:0]    cw_q, cw_d;
  logic              cw_valid_q, cw_valid_d;
  logic              error_q, error_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      asm_q      <= '0;
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      asm_q      <= asm_d;
      cw_q       <= cw_d;
      cw_valid_q <= cw_valid_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    sr_d               = sr_q;
    cnt_d              = cnt_q;
    tmo_d              = tmo_q;
    asm_d              = asm_q;
    cw_d               = cw_q;
    cw_valid_d         = 1'b0;
    error_d            = error_q;
    ready              = 1'b0;
    dec_databus        = '0;
    dec_first_data     = 1'b0;
    dec_data_valid     = 1'b0;
    dec_first_data_out = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          sr_d    = {llr_in, {LLR_CHUNK{1'b0}}};
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = S_SEND_F;
        end
      end
      S_SEND_F: begin
        if (!dec_busy) begin
          dec_first_data = 1'b1;
          dec_data_valid = 1'b1;
          dec_databus    = LLR_CHUNK'(sr_q[SR_W-1 -: FIRST_CHUNK]);
          sr_d           = sr_q << FIRST_CHUNK;
          state_d        = (L_SEG == 0) ? S_WAIT_RDY : S_SEND;
        end
      end
      S_SEND: begin
        if (!hold) begin
          dec_data_valid = 1'b1;
          dec_databus    = sr_q[SR_W-1 -: LLR_CHUNK];
          sr_d           = sr_q << LLR_CHUNK;
          cnt_d          = cnt_q + 8'd1;
          if (cnt_q == 8'(L_SEG - 1)) state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        dec_first_data_out = dec_out_ready;
        if (dec_out_ready) begin
          tmo_d   = '0;
          cnt_d   = '0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (dec_data_valid_out) begin
          tmo_d = '0;
          cnt_d = cnt_q + 8'd1;
          // First beat carries the short top chunk in its low bits; the rest is padding.
          if (cnt_q == 8'd0) asm_d = N_V'(dec_databus_out[FIRST_CHUNK_OUT-1:0]);
          else               asm_d = (asm_q << WIDTH_OUT) | N_V'(dec_databus_out);
          if (cnt_q == 8'(L_SEG_OUT)) state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == 8'(TIMEOUT - 1)) state_d = S_ERR;
        end
      end
      S_DONE: begin
        cw_d       = asm_q;
        cw_valid_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cw          = cw_q;
  assign cw_valid    = cw_valid_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_decoder_host.sv
// Bench for decoder_host: random LLR vectors and codeword beats checked against a
// reference built from LLR indices and byte arithmetic.
module tb_decoder_host;

  localparam int WI = 8, NL = 4, WO = 8, NV = 31, TO = 64;
  localparam int VW = WI * NV;
  localparam int BW = NL * WI;
  localparam int FIRST_LLRS = (NV - 1) % NL + 1;
  localparam int FOUT = (NV - 1) % WO + 1;
  localparam int NBEATS_OUT = (NV - 1) / WO + 1;

  logic          clk, rst, start, hold;
  logic [VW-1:0] llr_in;
  logic          ready, cw_valid, error;
  logic [NV-1:0] cw;
  logic [BW-1:0] dec_databus;
  logic          dec_first_data, dec_data_valid;
  logic          dec_busy, dec_out_ready, dec_first_data_out;
  logic [WO-1:0] dec_databus_out;
  logic          dec_data_valid_out;
  logic [2:0]    dbg_state;

  decoder_host #(.WIDTH_IN(WI), .N_LLRS(NL), .WIDTH_OUT(WO), .N_V(NV), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .llr_in(llr_in), .hold(hold),
    .ready(ready), .cw(cw), .cw_valid(cw_valid), .error(error),
    .dec_databus(dec_databus), .dec_first_data(dec_first_data),
    .dec_data_valid(dec_data_valid), .dec_busy(dec_busy),
    .dec_out_ready(dec_out_ready), .dec_first_data_out(dec_first_data_out),
    .dec_databus_out(dec_databus_out), .dec_data_valid_out(dec_data_valid_out),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [BW:0]   exp_q[$];
  logic [BW:0]   mon_e;
  logic [BW-1:0] beat_log[16];
  int            checks = 0;
  int            errs = 0;
  int            beats_seen = 0;
  int            fdo_cnt = 0;
  int            cv_cnt = 0;
  logic [NV-1:0] last_cw = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected beats straight from LLR indices: a short first beat of the top LLRs,
  // then groups of NL LLRs walking down to LLR 0.
  task automatic build_exp(input logic [VW-1:0] v);
    logic [BW-1:0] b;
    int idx;
    b = '0;
    for (int k = NV - 1; k >= NV - FIRST_LLRS; k--) b = (b << WI) | BW'(v[k*WI +: WI]);
    exp_q.push_back({1'b1, b});
    idx = NV - FIRST_LLRS - 1;
    while (idx >= 0) begin
      b = '0;
      for (int j = 0; j < NL; j++) begin
        b = (b << WI) | BW'(v[idx*WI +: WI]);
        idx--;
      end
      exp_q.push_back({1'b0, b});
    end
  endtask

  // Monitor: every beat is matched against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (dec_data_valid) begin
        if (beats_seen < 16) beat_log[beats_seen] = dec_databus;
        beats_seen++;
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_first_flag", dec_first_data, mon_e[BW]);
          chk("beat_data", dec_databus, mon_e[BW-1:0]);
        end
      end else begin
        chk("idle_bus_zero", {dec_databus, dec_first_data}, 0);
      end
      if (hold) chk("hold_no_beat", dec_data_valid & ~dec_first_data, 0);
      if (dec_first_data_out) fdo_cnt++;
      if (cw_valid) cv_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_vec(output logic [VW-1:0] v);
    for (int k = 0; k < NV; k++) v[k*WI +: WI] = WI'($urandom_range(0, 255));
  endtask

  // hold_mode: 0 none, 1 random, 2 three cycles early in the body. abort_at>0 resets mid-load.
  task automatic run_load(input logic [VW-1:0] v, input int busy_cyc, input int hold_mode,
                          input int abort_at);
    int cyc;
    bit done;
    bit aborted;
    exp_q.delete();
    beats_seen = 0;
    build_exp(v);
    @(posedge clk); #1;
    llr_in = v; start = 1'b1; dec_busy = (busy_cyc > 0); hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    llr_in = ~v;
    for (int i = 0; i < busy_cyc; i++) begin
      @(negedge clk);
      chk("busy_no_valid", dec_data_valid, 0);
      @(posedge clk); #1;
    end
    dec_busy = 1'b0;
    @(negedge clk);
    chk("first_beat_on_release", {dec_data_valid, dec_first_data}, 2'b11);
    #1;
    cyc = 0; done = 0; aborted = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      case (hold_mode)
        1: hold = 1'($urandom_range(0, 1));
        2: hold = (cyc >= 1 && cyc < 4);
        default: hold = 1'b0;
      endcase
      @(negedge clk); #1;
      if (abort_at > 0 && beats_seen >= abort_at) begin
        rst = 1'b0;
        #1;
        chk("rst_valid", dec_data_valid, 0);
        chk("rst_first", dec_first_data, 0);
        chk("rst_bus", dec_databus, 0);
        chk("rst_fdo", dec_first_data_out, 0);
        chk("rst_ready", ready, 1);
        chk("rst_cw", cw, 0);
        chk("rst_cw_valid", cw_valid, 0);
        chk("rst_error", error, 0);
        exp_q.delete();
        hold = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        aborted = 1;
        done = 1;
      end else if (exp_q.size() == 0) begin
        done = 1;
      end
      cyc++;
    end
    hold = 1'b0;
    if (!aborted) begin
      chk("load_complete", exp_q.size(), 0);
      chk("load_beat_count", beats_seen, 1 + (NV - FIRST_LLRS) / NL);
    end
  endtask

  task automatic run_recv(input bit directed, input logic [31:0] fixed);
    logic [7:0] b;
    logic [63:0] expv;
    int gap;
    bit got;
    fdo_cnt = 0; cv_cnt = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("fdo_needs_ready", dec_first_data_out, 0);
    @(posedge clk); #1;
    dec_out_ready = 1'b1;
    @(negedge clk);
    chk("fdo_pulse", dec_first_data_out, 1);
    @(posedge clk); #1;
    dec_out_ready = 1'b0;
    expv = 0;
    for (int i = 0; i < NBEATS_OUT; i++) begin
      b   = directed ? fixed[31 - 8*i -: 8] : 8'($urandom_range(0, 255));
      gap = directed ? 0 : $urandom_range(0, 6);
      repeat (gap) begin @(posedge clk); #1; end
      dec_data_valid_out = 1'b1;
      dec_databus_out = b;
      expv = (i == 0) ? (64'(b) % (64'd1 << FOUT)) : (expv * 256 + 64'(b));
      @(posedge clk); #1;
      dec_data_valid_out = 1'b0;
      dec_databus_out = 8'($urandom_range(0, 255));
    end
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (cw_valid) begin
        chk("cw_value", cw, expv);
        got = 1;
      end
    end
    chk("cw_valid_seen", got, 1);
    repeat (3) @(negedge clk);
    chk("cw_valid_once", cv_cnt, 1);
    chk("fdo_once", fdo_cnt, 1);
    chk("ready_after_done", ready, 1);
    chk("cw_held", cw, expv);
    last_cw = expv[NV-1:0];
  endtask

  // ---------------- directed sequence ----------------
  logic [VW-1:0] v;
  int t_err;
  bit seen_err;

  initial begin
    rst = 1'b0; start = 1'b0; hold = 1'b0; llr_in = '0;
    dec_busy = 1'b0; dec_out_ready = 1'b0; dec_databus_out = '0; dec_data_valid_out = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_cw", cw, 0);
    chk("reset_cw_valid", cw_valid, 0);
    chk("reset_error", error, 0);
    chk("reset_bus", dec_databus, 0);
    chk("reset_flags", {dec_first_data, dec_data_valid, dec_first_data_out}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // LLR k = k, no throttling, then a known codeword with a padding bit set.
    for (int k = 0; k < NV; k++) v[k*WI +: WI] = WI'(k);
    run_load(v, 0, 0, 0);
    chk("idx_beat1", beat_log[0], 32'h001E1D1C);
    chk("idx_beat2", beat_log[1], 32'h1B1A1918);
    chk("idx_beat8", beat_log[7], 32'h03020100);
    run_recv(1'b1, 32'h92345678);
    chk("cw_known", cw, 31'h12345678);

    // Decoder busy for 5 cycles after start.
    rand_vec(v);
    run_load(v, 5, 0, 0);
    run_recv(1'b0, 32'h0);

    // Three hold cycles mid-body.
    rand_vec(v);
    run_load(v, 0, 2, 0);
    run_recv(1'b0, 32'h0);

    // Random busy and hold.
    for (int r = 0; r < 4; r++) begin
      rand_vec(v);
      run_load(v, $urandom_range(0, 3), 1, 0);
      run_recv(1'b0, 32'h0);
    end

    // Receive timeout.
    rand_vec(v);
    run_load(v, 0, 0, 0);
    cv_cnt = 0;
    @(posedge clk); #1;
    dec_out_ready = 1'b1;
    @(posedge clk); #1;
    dec_out_ready = 1'b0;
    repeat (60) @(negedge clk);
    chk("no_error_early", error, 0);
    seen_err = 0;
    t_err = 0;
    for (int k = 0; k < 20 && !seen_err; k++) begin
      @(negedge clk);
      if (error) seen_err = 1;
      t_err = k;
    end
    chk("timeout_error", error, 1);
    chk("timeout_no_cw_valid", cv_cnt, 0);
    chk("timeout_ready", ready, 1);
    chk("timeout_cw_kept", cw, last_cw);
    repeat (3) @(negedge clk);
    chk("error_sticky", error, 1);

    // Next start clears error and works normally.
    rand_vec(v);
    run_load(v, 0, 0, 0);
    chk("error_cleared", error, 0);
    run_recv(1'b0, 32'h0);

    // Reset during the fourth beat, then a full transfer.
    rand_vec(v);
    run_load(v, 0, 0, 4);
    chk("post_rst_ready", ready, 1);
    for (int k = 0; k < NV; k++) v[k*WI +: WI] = WI'(k);
    run_load(v, 0, 0, 0);
    chk("post_rst_beat1", beat_log[0], 32'h001E1D1C);
    run_recv(1'b0, 32'h0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
